// File: rtl/hs_rr_arbiter_pkg.sv
// Shared definitions for the four-phase round-robin arbiter.
//   state_t    : FSM encoding (IDLE / REQ / ACK)
//   N_REQ_DEF  : default number of requesters
//   DATA_W_DEF : default data width per requester
package hs_arb_pkg;

  localparam int unsigned N_REQ_DEF  = 2;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/hs_rr_arbiter_sync2.sv
// hs_sync2: single-bit two-flop synchroniser, asynchronous active-low reset.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset (both flops clear to 0)
//   d     : asynchronous input bit
//   q     : synchronised output bit, two clk edges behind d
module hs_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hs_rr_arbiter.sv
// hs_rr_arbiter: N_REQ four-phase requesters funnelled round-robin into one
// four-phase output channel with bundled data. Moore FSM, registered outputs.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   in_req     : per-requester request           in_data : bundled data, DATA_W per requester
//   in_ack     : per-requester acknowledge (one-hot or zero)
//   out_req    : request to shared stage         out_data: latched winner data
//   out_ack    : acknowledge from shared stage
//   grant      : index of current/last winner    busy    : FSM not in IDLE
// Build option: define HS_SYNC_EN to pass in_req and out_ack through two-flop
// synchronisers (adds two cycles per input transition).
module hs_rr_arbiter
  import hs_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           in_req,
  input  logic [N_REQ*DATA_W-1:0]    in_data,
  output logic [N_REQ-1:0]           in_ack,
  output logic                       out_req,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ack,
  output logic [$clog2(N_REQ)-1:0]   grant,
  output logic                       busy
);

  localparam int unsigned GW = $clog2(N_REQ);

  logic [N_REQ-1:0]  req_s;
  logic              ack_s;

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_d, last_q, last_d;
  logic [DATA_W-1:0] data_d;

  logic              found;
  logic [GW-1:0]     pick;
  logic [GW:0]       sum;
  logic [DATA_W-1:0] pick_data;

  logic              out_req_d, busy_d;
  logic [N_REQ-1:0]  in_ack_d;

`ifdef HS_SYNC_EN
  for (genvar g = 0; g < N_REQ; g++) begin : g_sync_req
    hs_sync2 u_sync_req (.clk(clk), .rst_n(rst_n), .d(in_req[g]), .q(req_s[g]));
  end
  hs_sync2 u_sync_ack (.clk(clk), .rst_n(rst_n), .d(out_ack), .q(ack_s));
`else
  assign req_s = in_req;
  assign ack_s = out_ack;
`endif

  // State and registered outputs; outputs are decoded from the next state so
  // they change on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant    <= '0;
      out_data <= '0;
      last_q   <= GW'(N_REQ - 1);
      out_req  <= 1'b0;
      in_ack   <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant    <= grant_d;
      out_data <= data_d;
      last_q   <= last_d;
      out_req  <= out_req_d;
      in_ack   <= in_ack_d;
      busy     <= busy_d;
    end
  end

  always_comb begin
    found     = 1'b0;
    pick      = '0;
    sum       = '0;
    pick_data = '0;
    // Scan from last+1 upward, wrapping modulo N_REQ without a divider:
    // last+1+i never exceeds 2*N_REQ-1, so one conditional subtract suffices.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      sum = {1'b0, last_q} + (GW+1)'(i + 1);
      if (sum >= (GW+1)'(N_REQ)) sum = sum - (GW+1)'(N_REQ);
      if (!found && req_s[sum[GW-1:0]]) begin
        found = 1'b1;
        pick  = sum[GW-1:0];
      end
    end
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (pick == GW'(j)) pick_data = in_data[j*DATA_W +: DATA_W];
    end

    state_d = state_q;
    grant_d = grant;
    data_d  = out_data;
    last_d  = last_q;
    unique case (state_q)
      IDLE: if (found) begin
        state_d = REQ;
        grant_d = pick;
        data_d  = pick_data;
      end
      REQ:  if (ack_s) state_d = ACK;
      ACK:  if (!req_s[grant] && !ack_s) begin
        state_d = IDLE;
        last_d  = grant;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_req_d = (state_d == REQ);
    busy_d    = (state_d != IDLE);
    in_ack_d  = '0;
    if (state_d == ACK) in_ack_d[grant_d] = 1'b1;
  end

endmodule

// File: tb/tb_hs_rr_arbiter.sv
module tb_hs_rr_arbiter;

`ifdef HS_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int HOLD = 1 + SYNC_LAT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  in_req;
  logic [15:0] in_data;
  logic [1:0]  in_ack;
  logic        out_req;
  logic [7:0]  out_data;
  logic        out_ack;
  logic [0:0]  grant;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int both_ack = 0;

  hs_rr_arbiter #(.N_REQ(2), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_data(in_data),
    .in_ack(in_ack), .out_req(out_req), .out_data(out_data),
    .out_ack(out_ack), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (in_ack == 2'b11) both_ack++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  typedef struct {
    logic [1:0] req;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       ack;
    logic       e_oreq;
    logic [1:0] e_iack;
    logic       e_grant;
    logic [7:0] e_data;
    logic       e_busy;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    in_req  = 2'b00;
    in_data = 16'h0000;
    out_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full four-phase transfer by whichever requester wins; the winner
  // drops and then re-raises its request once the arbiter returns to IDLE.
  task automatic xfer(output logic g);
    int n;
    g = 1'b0;
    n = 0;
    while (!out_req && n < 20) begin tick(); n++; end
    if (!out_req) chk("xfer_req_timeout", 32'd1, 32'd0);
    g = grant;
    out_ack = 1'b1;
    n = 0;
    while (!in_ack[g] && n < 20) begin tick(); n++; end
    if (!in_ack[g]) chk("xfer_ack_timeout", 32'd1, 32'd0);
    in_req[g] = 1'b0;
    out_ack   = 1'b0;
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    if (busy) chk("xfer_idle_timeout", 32'd1, 32'd0);
    in_req[g] = 1'b1;
  endtask

  initial begin
    int n;
    int viol;
    logic g;
    logic [0:0] exp_g[3];
    exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0;

    //            req    d0     d1     ack   oreq  iack   gnt   data   busy
    tbl[0]  = '{2'b01, 8'hA5, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 8'hA5, 1'b1};
    tbl[1]  = '{2'b01, 8'hA5, 8'h00, 1'b1, 1'b0, 2'b01, 1'b0, 8'hA5, 1'b1};
    tbl[2]  = '{2'b00, 8'hA5, 8'h00, 1'b1, 1'b0, 2'b01, 1'b0, 8'hA5, 1'b1};
    tbl[3]  = '{2'b00, 8'hA5, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 8'hA5, 1'b0};
    tbl[4]  = '{2'b11, 8'h11, 8'h3C, 1'b0, 1'b1, 2'b00, 1'b1, 8'h3C, 1'b1};
    tbl[5]  = '{2'b11, 8'h11, 8'hFF, 1'b0, 1'b1, 2'b00, 1'b1, 8'h3C, 1'b1};
    tbl[6]  = '{2'b11, 8'h11, 8'hFF, 1'b1, 1'b0, 2'b10, 1'b1, 8'h3C, 1'b1};
    tbl[7]  = '{2'b01, 8'h11, 8'hFF, 1'b1, 1'b0, 2'b10, 1'b1, 8'h3C, 1'b1};
    tbl[8]  = '{2'b00, 8'h11, 8'hFF, 1'b0, 1'b0, 2'b00, 1'b1, 8'h3C, 1'b0};
    tbl[9]  = '{2'b11, 8'h5A, 8'h3C, 1'b0, 1'b1, 2'b00, 1'b0, 8'h5A, 1'b1};
    tbl[10] = '{2'b11, 8'h5A, 8'h3C, 1'b1, 1'b0, 2'b01, 1'b0, 8'h5A, 1'b1};
    tbl[11] = '{2'b00, 8'h5A, 8'h3C, 1'b0, 1'b0, 2'b00, 1'b0, 8'h5A, 1'b0};

    rst_n   = 1'b0;
    in_req  = 2'b00;
    in_data = 16'h0000;
    out_ack = 1'b0;
    #1;
    chk("rst_out_req",  32'(out_req),  32'd0);
    chk("rst_in_ack",   32'(in_ack),   32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_grant",    32'(grant),    32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      in_req  = tbl[i].req;
      in_data = {tbl[i].d1, tbl[i].d0};
      out_ack = tbl[i].ack;
      repeat (HOLD) tick();
      chk($sformatf("vec%0d_out_req", i),  32'(out_req),  32'(tbl[i].e_oreq));
      chk($sformatf("vec%0d_in_ack", i),   32'(in_ack),   32'(tbl[i].e_iack));
      chk($sformatf("vec%0d_grant", i),    32'(grant),    32'(tbl[i].e_grant));
      chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_data));
      chk($sformatf("vec%0d_busy", i),     32'(busy),     32'(tbl[i].e_busy));
    end

    // Single request latency and echo
    do_reset();
    in_data = 16'h00A5;
    in_req  = 2'b01;
    n = 0;
    do begin tick(); n++; end while (!out_req && n < 10);
    chk("lat_out_req_cycles", 32'(n), 32'(HOLD));
    chk("lat_out_data", 32'(out_data), 32'hA5);
    chk("lat_grant",    32'(grant),    32'd0);
    out_ack = 1'b1;
    n = 0;
    do begin tick(); n++; end while (in_ack != 2'b01 && n < 10);
    chk("lat_in_ack_cycles", 32'(n), 32'(HOLD));
    in_req  = 2'b00;
    out_ack = 1'b0;
    n = 0;
    do begin tick(); n++; end while (busy && n < 10);
    chk("lat_idle_cycles", 32'(n), 32'(HOLD));

    // Rotation under continuous contention
    do_reset();
    in_data = 16'h2211;
    in_req  = 2'b11;
    for (int t = 0; t < 3; t++) begin
      xfer(g);
      chk($sformatf("rr_grant%0d", t), 32'(g), 32'(exp_g[t]));
    end
    chk("rr_in_ack_never_11", 32'(both_ack), 32'd0);

    // Return-to-zero hold: out_ack stays high after the requester leaves
    do_reset();
    in_data = 16'h9977;
    in_req  = 2'b01;
    n = 0;
    while (!out_req && n < 10) begin tick(); n++; end
    out_ack = 1'b1;
    n = 0;
    while (in_ack != 2'b01 && n < 10) begin tick(); n++; end
    chk("rtz_in_ack", 32'(in_ack), 32'b01);
    in_req = 2'b10;
    viol = 0;
    repeat (10) begin
      tick();
      if (out_req || !busy) viol++;
    end
    chk("rtz_no_req_while_ack", 32'(viol), 32'd0);
    out_ack = 1'b0;
    repeat (HOLD) tick();
    chk("rtz_idle_out_req", 32'(out_req), 32'd0);
    chk("rtz_idle_busy",    32'(busy),    32'd0);
    tick();
    chk("rtz_next_out_req",  32'(out_req),  32'd1);
    chk("rtz_next_grant",    32'(grant),    32'd1);
    chk("rtz_next_out_data", 32'(out_data), 32'h99);

    // Asynchronous reset while in ACK
    out_ack = 1'b1;
    n = 0;
    while (in_ack != 2'b10 && n < 10) begin tick(); n++; end
    chk("mid_in_ack_before", 32'(in_ack), 32'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ack",   32'(in_ack),   32'd0);
    chk("mid_rst_out_req",  32'(out_req),  32'd0);
    chk("mid_rst_busy",     32'(busy),     32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    in_req  = 2'b11;
    out_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (HOLD) tick();
    chk("mid_after_out_req", 32'(out_req),  32'd1);
    chk("mid_after_grant",   32'(grant),    32'd0);
    chk("mid_after_data",    32'(out_data), 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
